alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Front-panel controller for the alarm clock datapath. It turns three synchronized push-buttons into the datapath control signals: `Timeset`, `Alarmset`, `Minadv`, `Hrsadv` and `Dayadv`. It also owns the buzzer policy: ring, snooze, dismiss. It sits between the panel button synchronizers and the clock/alarm datapath, and takes the datapath's `AlarmMatch` flag and one-second `Tick` as inputs.

## Interface
Parameters:
- `HOLD_CYCLES`, default 8: clock cycles an advance button must stay held, counted from its rising edge, before auto-repeat starts.
- `REPEAT_CYCLES`, default 4: clock cycles between auto-repeat strobes.
- `SNOOZE_TICKS`, default 540: `Tick` strobes in one snooze period (9 min).

Ports:
- `Clk`  in  1  single clock; every register is clocked on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Tick`  in  1  one-cycle strobe, once per second, from the time base.
- `ModeBtn`  in  1  synchronized level; a rising edge advances the mode or dismisses the alarm.
- `AdvBtn`  in  1  synchronized level; advances the field selected by the current mode.
- `SnoozeBtn`  in  1  synchronized level; a rising edge snoozes a ringing alarm.
- `AlarmMatch`  in  1  level from the datapath; high while current time equals alarm time on an enabled day.
- `Alarmon`  in  1  alarm enable switch.
- `Timeset`  out  1  high in modes SET_DAY, SET_HRS and SET_MIN.
- `Alarmset`  out  1  high in modes ALM_HRS and ALM_MIN.
- `Dayadv`, `Hrsadv`, `Minadv`  out  1 each  one-cycle advance strobes.
- `Buzz`  out  1  buzzer drive.
- `Mode`  out  3  current mode encoding, used by the display mux.

## Operation
- Edge detection: each button has a previous-value register. On reset this register is set to 1, so a button held through reset must be released before it registers a press.
- Mode FSM: RUN(0) → SET_DAY(1) → SET_HRS(2) → SET_MIN(3) → ALM_HRS(4) → ALM_MIN(5) → RUN. Each `ModeBtn` rising edge moves one step. Encodings 6 and 7 are illegal and return to RUN on the next cycle.
- Advance field routing:
  - SET_DAY drives `Dayadv`.
  - SET_HRS and ALM_HRS drive `Hrsadv`.
  - SET_MIN and ALM_MIN drive `Minadv`.
  - In RUN, `AdvBtn` is ignored and its repeat counter is held at 0.
- Auto-repeat:
  - An `AdvBtn` rising edge gives one strobe.
  - If the button is still high `HOLD_CYCLES` cycles after the edge, a strobe follows, then one every `REPEAT_CYCLES` cycles while it stays high.
  - Releasing the button clears the counter.
  - A mode change clears the counter and suppresses any strobe in the cycle of the change.
- Buzz FSM (B_IDLE, B_RING, B_SNOOZE, B_DONE):
  - B_IDLE → B_RING on a rising edge of `AlarmMatch`, qualified by `Alarmon`=1 and Mode=RUN.
  - B_RING: `Buzz`=1.
    - `SnoozeBtn` edge → B_SNOOZE, with the counter loaded to `SNOOZE_TICKS`.
    - `ModeBtn` edge → B_DONE.
  - B_SNOOZE: the counter decrements on each `Tick`. When it reaches 0 the FSM goes to B_RING. A `ModeBtn` edge goes to B_DONE.
  - B_DONE: waits for `AlarmMatch`=0, then goes to B_IDLE.
  - From any state, `Alarmon`=0 → B_IDLE and `Buzz`=0.
- Button priority: while the Buzz FSM is in B_RING or B_SNOOZE, a `ModeBtn` edge only dismisses; it does not advance the mode. `SnoozeBtn` is ignored in every other state.
- Snooze counter: 10 bits, ≥ clog2(`SNOOZE_TICKS`+1), unsigned, saturates at 0.

## Timing
- Reset values:
  - Mode=RUN and Buzz FSM=B_IDLE.
  - All outputs 0: `Timeset`, `Alarmset`, `Dayadv`, `Hrsadv`, `Minadv`, `Buzz`.
  - Counters at 0.
- Latency: all outputs are registered.
  - A button edge sampled at cycle n changes Mode, `Timeset`/`Alarmset` or a strobe at n+1.
  - `Buzz` rises one cycle after `AlarmMatch` rises.
- Auto-repeat schedule, with the edge sampled at cycle n: strobes at n+1, n+1+`HOLD_CYCLES`, then every `REPEAT_CYCLES` after that.
- Strobes never exceed 1 cycle and never overlap: at most one advance output is high per cycle.
- Reset asserted mid-operation (mid-repeat or mid-snooze) returns everything to reset values at the next edge.
- `Tick` arriving in the same cycle as a `SnoozeBtn` edge: the counter loads `SNOOZE_TICKS` and the tick is not counted.

## Structure
- Package `alarm_ctrl_pkg` holds:
  - `mode_t`, a 3-bit enum with RUN..ALM_MIN.
  - `buzz_t`, a 2-bit enum for the Buzz FSM.
  - Default parameter constants.
- Sub-module `btn_repeat`, instantiated once for `AdvBtn`: edge detect plus hold/repeat counter, parameterized by `HOLD_CYCLES` and `REPEAT_CYCLES`, with an `en` input so it is disabled in RUN.
- Mode FSM, Buzz FSM, field routing and snooze counter live in the top module.

## Test plan
- Reset: hold `Reset` 2 cycles with `ModeBtn`=1, then release → Mode=0 and all outputs 0. No mode change until `ModeBtn` goes low and then high.
- Mode cycle: 6 `ModeBtn` pulses.
  - Mode goes 1,2,3,4,5,0.
  - `Timeset`=1 only for Mode 1–3; `Alarmset`=1 only for Mode 4–5.
- Advance field, single press: Mode=2, one-cycle `AdvBtn` pulse → exactly one `Hrsadv` strobe, one cycle later, and no `Minadv` or `Dayadv`.
- Auto-repeat: Mode=3, `AdvBtn` held 20 cycles with default parameters → `Minadv` strobes at +1, +9, +13, +17 relative to the edge, and none after release.
- Ring and snooze: Mode=0, `Alarmon`=1, `AlarmMatch` rises.
  - `Buzz`=1 next cycle.
  - `SnoozeBtn` edge → `Buzz`=0.
  - After 540 `Tick`s → `Buzz`=1.
  - `ModeBtn` edge → `Buzz`=0 and Mode stays 0.
- Alarm disable: while ringing, `Alarmon`=0 → `Buzz`=0 next cycle. `AlarmMatch` rising in Mode=2 → `Buzz` stays 0.

Source files
------------

// File: rtl/alarm_ctrl_pkg.sv
// Shared types and defaults for the alarm clock front-panel controller.
package alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_RUN     = 3'd0,
        MODE_SET_DAY = 3'd1,
        MODE_SET_HRS = 3'd2,
        MODE_SET_MIN = 3'd3,
        MODE_ALM_HRS = 3'd4,
        MODE_ALM_MIN = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_RING   = 2'd1,
        B_SNOOZE = 2'd2,
        B_DONE   = 2'd3
    } buzz_t;

    localparam int DEF_HOLD_CYCLES   = 8;
    localparam int DEF_REPEAT_CYCLES = 4;
    localparam int DEF_SNOOZE_TICKS  = 540;
    localparam int SNOOZE_W          = 10;

    // Step through the mode ring; anything past ALM_MIN wraps to RUN.
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        if (m >= 3'(MODE_ALM_MIN)) begin
            return 3'(MODE_RUN);
        end
        return m + 3'd1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_btn_repeat.sv
// Edge detector plus hold/auto-repeat timer for one button; fire is a
// combinational one-cycle request that the parent registers.
module btn_repeat
    import alarm_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic btn,
    output logic fire
);

    localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;

    // cnt counts cycles since the last strobe; 0 means idle. rep marks the
    // switch from the initial hold delay to the repeat period.
    always_comb begin
        prev_d = btn;
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        fire   = 1'b0;
        if (!en || clr || !btn) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!prev_q) begin
            fire  = 1'b1;
            cnt_d = ONE_C;
            rep_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (!rep_q && cnt_q == HOLD_C) begin
                fire  = 1'b1;
                cnt_d = ONE_C;
                rep_d = 1'b1;
            end else if (rep_q && cnt_q == REP_C) begin
                fire  = 1'b1;
                cnt_d = ONE_C;
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
            cnt_q  <= '0;
            rep_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Front-panel controller: mode FSM, advance routing with auto-repeat, and
// the ring/snooze/dismiss buzzer policy. All outputs are registered.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int SNOOZE_TICKS  = DEF_SNOOZE_TICKS
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       ModeBtn,
    input  logic       AdvBtn,
    input  logic       SnoozeBtn,
    input  logic       AlarmMatch,
    input  logic       Alarmon,
    output logic       Timeset,
    output logic       Alarmset,
    output logic       Dayadv,
    output logic       Hrsadv,
    output logic       Minadv,
    output logic       Buzz,
    output logic [2:0] Mode
);

    localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_TICKS);
    localparam logic [SNOOZE_W-1:0] SNZ_ONE     = SNOOZE_W'(1);

    logic [2:0]          mode_q, mode_d;
    buzz_t               buzz_st_q, buzz_st_d;
    logic [SNOOZE_W-1:0] snz_cnt_q, snz_cnt_d;
    logic                mode_prev_q, snz_prev_q, match_prev_q;
    logic                timeset_q, timeset_d, alarmset_q, alarmset_d;
    logic                dayadv_q, dayadv_d, hrsadv_q, hrsadv_d, minadv_q, minadv_d;
    logic                buzz_q, buzz_d;

    logic mode_edge, snz_edge, match_edge, alarm_active, mode_chg;
    logic adv_fire, adv_ok;

    assign mode_edge    = ModeBtn & ~mode_prev_q;
    assign snz_edge     = SnoozeBtn & ~snz_prev_q;
    assign match_edge   = AlarmMatch & ~match_prev_q;
    assign alarm_active = (buzz_st_q == B_RING) || (buzz_st_q == B_SNOOZE);

    // While the alarm is ringing or snoozed, ModeBtn is reserved for dismiss.
    always_comb begin
        mode_d = mode_q;
        if (mode_q > 3'(MODE_ALM_MIN)) begin
            mode_d = 3'(MODE_RUN);
        end else if (mode_edge && !alarm_active) begin
            mode_d = next_mode(mode_q);
        end
    end

    assign mode_chg = (mode_d != mode_q);

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_adv (
        .clk  (Clk),
        .reset(Reset),
        .en   (mode_q != 3'(MODE_RUN)),
        .clr  (mode_chg),
        .btn  (AdvBtn),
        .fire (adv_fire)
    );

    assign adv_ok = adv_fire & ~mode_chg;

    always_comb begin
        timeset_d  = (mode_d >= 3'(MODE_SET_DAY)) && (mode_d <= 3'(MODE_SET_MIN));
        alarmset_d = (mode_d == 3'(MODE_ALM_HRS)) || (mode_d == 3'(MODE_ALM_MIN));
        dayadv_d   = adv_ok && (mode_q == 3'(MODE_SET_DAY));
        hrsadv_d   = adv_ok && ((mode_q == 3'(MODE_SET_HRS)) || (mode_q == 3'(MODE_ALM_HRS)));
        minadv_d   = adv_ok && ((mode_q == 3'(MODE_SET_MIN)) || (mode_q == 3'(MODE_ALM_MIN)));
    end

    always_comb begin
        buzz_st_d = buzz_st_q;
        snz_cnt_d = snz_cnt_q;
        if (!Alarmon) begin
            buzz_st_d = B_IDLE;
            snz_cnt_d = '0;
        end else begin
            case (buzz_st_q)
                B_IDLE: begin
                    if (match_edge && mode_q == 3'(MODE_RUN)) buzz_st_d = B_RING;
                end
                B_RING: begin
                    if (mode_edge) begin
                        buzz_st_d = B_DONE;
                    end else if (snz_edge) begin
                        buzz_st_d = B_SNOOZE;
                        snz_cnt_d = SNOOZE_LOAD;
                    end
                end
                B_SNOOZE: begin
                    if (mode_edge) begin
                        buzz_st_d = B_DONE;
                    end else if (snz_cnt_q == '0) begin
                        buzz_st_d = B_RING;
                    end else if (Tick) begin
                        snz_cnt_d = snz_cnt_q - SNZ_ONE;
                        if (snz_cnt_q == SNZ_ONE) buzz_st_d = B_RING;
                    end
                end
                B_DONE: begin
                    if (!AlarmMatch) buzz_st_d = B_IDLE;
                end
                default: buzz_st_d = B_IDLE;
            endcase
        end
        buzz_d = (buzz_st_d == B_RING);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q       <= 3'(MODE_RUN);
            buzz_st_q    <= B_IDLE;
            snz_cnt_q    <= '0;
            mode_prev_q  <= 1'b1;
            snz_prev_q   <= 1'b1;
            match_prev_q <= 1'b1;
            timeset_q    <= 1'b0;
            alarmset_q   <= 1'b0;
            dayadv_q     <= 1'b0;
            hrsadv_q     <= 1'b0;
            minadv_q     <= 1'b0;
            buzz_q       <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            buzz_st_q    <= buzz_st_d;
            snz_cnt_q    <= snz_cnt_d;
            mode_prev_q  <= ModeBtn;
            snz_prev_q   <= SnoozeBtn;
            match_prev_q <= AlarmMatch;
            timeset_q    <= timeset_d;
            alarmset_q   <= alarmset_d;
            dayadv_q     <= dayadv_d;
            hrsadv_q     <= hrsadv_d;
            minadv_q     <= minadv_d;
            buzz_q       <= buzz_d;
        end
    end

    assign Mode     = mode_q;
    assign Timeset  = timeset_q;
    assign Alarmset = alarmset_q;
    assign Dayadv   = dayadv_q;
    assign Hrsadv   = hrsadv_q;
    assign Minadv   = minadv_q;
    assign Buzz     = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: mode ring, advance routing, auto-repeat
// schedule, ring/snooze/dismiss and alarm disable.
module tb_alarm_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int SNZ  = 540;

    logic       Clk = 1'b0;
    logic       Reset, Tick, ModeBtn, AdvBtn, SnoozeBtn, AlarmMatch, Alarmon;
    logic       Timeset, Alarmset, Dayadv, Hrsadv, Minadv, Buzz;
    logic [2:0] Mode;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    alarm_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .SNOOZE_TICKS (SNZ)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .ModeBtn   (ModeBtn),
        .AdvBtn    (AdvBtn),
        .SnoozeBtn (SnoozeBtn),
        .AlarmMatch(AlarmMatch),
        .Alarmon   (Alarmon),
        .Timeset   (Timeset),
        .Alarmset  (Alarmset),
        .Dayadv    (Dayadv),
        .Hrsadv    (Hrsadv),
        .Minadv    (Minadv),
        .Buzz      (Buzz),
        .Mode      (Mode)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic press_mode();
        ModeBtn = 1'b1;
        step();
        ModeBtn = 1'b0;
        step();
    endtask

    task automatic goto_mode(input logic [2:0] target);
        int n;
        n = 0;
        while (Mode !== target && n < 8) begin
            press_mode();
            n++;
        end
        checks++;
        if (Mode !== target) begin
            failures++;
            $display("FAIL goto_mode: Mode=%0d want %0d", Mode, target);
        end
    endtask

    // Reference schedule: a strobe one cycle after the edge, then one at
    // 1+HOLD and every REP after that, as long as the button was still held.
    function automatic void build_schedule(input int len, input bit repeat_on);
        exp_q.delete();
        exp_q.push_back(8'd1);
        if (repeat_on) begin
            for (int o = 1 + HOLD; o <= len; o += REP) exp_q.push_back(8'(o));
        end
    endfunction

    function automatic int sched_diff();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size()) return i;
            if (obs_q[i] != exp_q[i]) return i;
        end
        return -1;
    endfunction

    // Hold AdvBtn for len sampled cycles and record strobe offsets on the
    // selected field (0 day, 1 hrs, 2 min). mode_at>0 pulses ModeBtn so its
    // edge is sampled at that offset.
    task automatic run_hold(input int len, input int window, input int sel, input int mode_at,
                            output int wrong_cnt, output int overlap_cnt);
        logic [2:0] s;
        logic       hit;
        obs_q.delete();
        wrong_cnt   = 0;
        overlap_cnt = 0;
        AdvBtn = 1'b1;
        ModeBtn = (mode_at == 1);
        for (int c = 1; c <= window; c++) begin
            step();
            s   = {Dayadv, Hrsadv, Minadv};
            hit = (sel == 0) ? Dayadv : (sel == 1) ? Hrsadv : Minadv;
            if ($countones(s) > 1) overlap_cnt++;
            if (hit) obs_q.push_back(8'(c));
            if ($countones(s) > (hit ? 1 : 0)) wrong_cnt++;
            if (c == len) AdvBtn = 1'b0;
            ModeBtn = (c + 1 == mode_at);
        end
        AdvBtn  = 1'b0;
        ModeBtn = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ModeBtn = 1'b1; Tick = 1'b0; AdvBtn = 1'b0;
        SnoozeBtn = 1'b0; AlarmMatch = 1'b0; Alarmon = 1'b0;
        step();
        step();
        Reset = 1'b0;
        checks++;
        if (Mode !== 3'd0) begin
            failures++;
            $display("FAIL reset_mode: Mode=%0d want 0", Mode);
        end
        checks++;
        if ({Timeset, Alarmset, Dayadv, Hrsadv, Minadv, Buzz} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000", {Timeset, Alarmset, Dayadv, Hrsadv, Minadv, Buzz});
        end
        repeat (3) step();
        checks++;
        if (Mode !== 3'd0) begin
            failures++;
            $display("FAIL reset_held_btn: Mode=%0d want 0", Mode);
        end
        ModeBtn = 1'b0;
        step();
        ModeBtn = 1'b1;
        step();
        checks++;
        if (Mode !== 3'd1 || Timeset !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_press: Mode=%0d Timeset=%b want 1 1", Mode, Timeset);
        end
        ModeBtn = 1'b0;
        step();
        goto_mode(3'd0);
    endtask

    task automatic test_mode_cycle();
        int m;
        m = 0;
        for (int i = 0; i < 6; i++) begin
            press_mode();
            m = (m + 1) % 6;
            checks++;
            if (Mode !== 3'(m)) begin
                failures++;
                $display("FAIL mode_cycle: Mode=%0d want %0d", Mode, m);
            end
            checks++;
            if (Timeset !== (m >= 1 && m <= 3) || Alarmset !== (m >= 4)) begin
                failures++;
                $display("FAIL mode_flags: mode %0d Timeset=%b Alarmset=%b want %b %b",
                         m, Timeset, Alarmset, (m >= 1 && m <= 3), (m >= 4));
            end
        end
    endtask

    task automatic test_single_press();
        int w, o, d;
        goto_mode(3'd2);
        run_hold(1, 14, 1, 0, w, o);
        build_schedule(1, 1'b1);
        d = sched_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL single_press: Hrsadv count=%0d want %0d (first diff idx %0d)", obs_q.size(), exp_q.size(), d);
        end
        checks++;
        if (w != 0 || o != 0) begin
            failures++;
            $display("FAIL single_press_other: stray=%0d overlap=%0d want 0 0", w, o);
        end
    endtask

    task automatic test_auto_repeat();
        int w, o, d;
        goto_mode(3'd3);
        run_hold(20, 28, 2, 0, w, o);
        build_schedule(20, 1'b1);
        d = sched_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL auto_repeat: idx %0d got %0d strobes want %0d", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (w != 0 || o != 0) begin
            failures++;
            $display("FAIL auto_repeat_other: stray=%0d overlap=%0d want 0 0", w, o);
        end
    endtask

    task automatic test_random_repeat();
        int w, o, d, tm, len, sel;
        for (int it = 0; it < 8; it++) begin
            tm  = $urandom_range(1, 5);
            len = $urandom_range(1, 30);
            sel = (tm == 1) ? 0 : (tm == 2 || tm == 4) ? 1 : 2;
            goto_mode(3'(tm));
            run_hold(len, len + 8, sel, 0, w, o);
            build_schedule(len, 1'b1);
            d = sched_diff();
            checks++;
            if (d != -1 || w != 0 || o != 0) begin
                failures++;
                $display("FAIL random_repeat: mode %0d len %0d got %0d strobes want %0d stray=%0d overlap=%0d",
                         tm, len, obs_q.size(), exp_q.size(), w, o);
            end
            repeat ($urandom_range(1, 4)) step();
        end
    endtask

    task automatic test_mode_change_cut();
        int w, o, d;
        goto_mode(3'd2);
        run_hold(20, 28, 1, 1 + HOLD, w, o);
        build_schedule(20, 1'b0);
        d = sched_diff();
        checks++;
        if (d != -1 || w != 0) begin
            failures++;
            $display("FAIL mode_change_cut: Hrsadv count=%0d want %0d stray=%0d want 0", obs_q.size(), exp_q.size(), w);
        end
        checks++;
        if (Mode !== 3'd3) begin
            failures++;
            $display("FAIL mode_change_mode: Mode=%0d want 3", Mode);
        end
    endtask

    task automatic test_ring_snooze();
        bit quiet;
        goto_mode(3'd0);
        Alarmon = 1'b1;
        AlarmMatch = 1'b0;
        step();
        step();
        AlarmMatch = 1'b1;
        step();
        checks++;
        if (Buzz !== 1'b1) begin
            failures++;
            $display("FAIL ring_start: Buzz=%b want 1", Buzz);
        end
        SnoozeBtn = 1'b1;
        Tick = 1'b1;
        step();
        SnoozeBtn = 1'b0;
        Tick = 1'b0;
        checks++;
        if (Buzz !== 1'b0) begin
            failures++;
            $display("FAIL snooze_enter: Buzz=%b want 0", Buzz);
        end
        step();
        quiet = 1'b1;
        for (int i = 1; i <= SNZ; i++) begin
            Tick = 1'b1;
            step();
            Tick = 1'b0;
            if (i < SNZ) begin
                if (Buzz !== 1'b0) quiet = 1'b0;
                repeat ($urandom_range(0, 2)) step();
                if (Buzz !== 1'b0) quiet = 1'b0;
            end
        end
        checks++;
        if (Buzz !== 1'b1) begin
            failures++;
            $display("FAIL snooze_expire: Buzz=%b want 1 after %0d ticks", Buzz, SNZ);
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL snooze_quiet: Buzz rose before %0d ticks, want 0", SNZ);
        end
        ModeBtn = 1'b1;
        step();
        ModeBtn = 1'b0;
        checks++;
        if (Buzz !== 1'b0 || Mode !== 3'd0) begin
            failures++;
            $display("FAIL dismiss: Buzz=%b Mode=%0d want 0 0", Buzz, Mode);
        end
        step();
        checks++;
        if (Mode !== 3'd0) begin
            failures++;
            $display("FAIL dismiss_mode: Mode=%0d want 0", Mode);
        end
        AlarmMatch = 1'b0;
        step();
        step();
    endtask

    task automatic test_alarm_disable();
        bit quiet;
        AlarmMatch = 1'b1;
        step();
        checks++;
        if (Buzz !== 1'b1) begin
            failures++;
            $display("FAIL disable_ring: Buzz=%b want 1", Buzz);
        end
        Alarmon = 1'b0;
        step();
        checks++;
        if (Buzz !== 1'b0) begin
            failures++;
            $display("FAIL disable_off: Buzz=%b want 0", Buzz);
        end
        AlarmMatch = 1'b0;
        Alarmon = 1'b1;
        step();
        goto_mode(3'd2);
        AlarmMatch = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            step();
            if (Buzz !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL ring_in_set_mode: Buzz=1 want 0");
        end
        AlarmMatch = 1'b0;
        step();
        goto_mode(3'd0);
    endtask

    task automatic test_mid_reset();
        goto_mode(3'd3);
        AdvBtn = 1'b1;
        repeat (11) step();
        Reset = 1'b1;
        step();
        checks++;
        if (Mode !== 3'd0 || {Timeset, Alarmset, Dayadv, Hrsadv, Minadv, Buzz} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset: Mode=%0d outs=%b want 0 000000", Mode, {Timeset, Alarmset, Dayadv, Hrsadv, Minadv, Buzz});
        end
        Reset = 1'b0;
        AdvBtn = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_single_press();
        test_auto_repeat();
        test_random_repeat();
        test_mode_change_cut();
        test_ring_snooze();
        test_alarm_disable();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
